pcs_rx_decoder: RTL and testbench

- Receive-side counterpart of the 1000BASE-T PCS transmit Encoder.
- Accepts one 4D-PAM5 symbol quartet (A,B,C,D) per symbol strobe, plus the matching receive descrambler word Sd[8:0].
- Tracks stream delimiters (SSD/ESD) and decodes data quartets back to GMII-style rxd/rx_dv/rx_er.
- Sits between the receive descrambler/slicer and the GMII receive interface.

---
 rtl/pcs_pkg.sv | 94 +++++++++
 rtl/pcs_rx_symbol_lut.sv | 21 ++
 rtl/pcs_rx_decoder.sv | 142 ++++++++++++++
 tb/tb_pcs_rx_decoder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_pkg.sv
// Purpose: shared 1000BASE-T PCS types, delimiter quartets and data symbol mapping.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package pcs_pkg;

    typedef logic signed [2:0] pam5_t;

    // Field a is the most significant, so {A,B,C,D} concatenates straight into a quartet.
    typedef struct packed {
        pam5_t a;
        pam5_t b;
        pam5_t c;
        pam5_t d;
    } quartet_t;

    typedef enum logic [1:0] {
        RX_IDLE     = 2'd0,
        RX_SSD_WAIT = 2'd1,
        RX_DATA     = 2'd2,
        RX_ESD_WAIT = 2'd3
    } rx_state_t;

    localparam pam5_t PAM5_P2 = 3'sb010;
    localparam pam5_t PAM5_M2 = 3'sb110;

    localparam quartet_t SSD1        = '{a: PAM5_P2, b: PAM5_P2, c: PAM5_P2, d: PAM5_P2};
    localparam quartet_t SSD2        = '{a: PAM5_P2, b: PAM5_P2, c: PAM5_P2, d: PAM5_M2};
    localparam quartet_t ESD1        = SSD1;
    localparam quartet_t ESD2_EXT0   = SSD2;
    localparam quartet_t ESD2_EXT1   = '{a: PAM5_P2, b: PAM5_P2, c: PAM5_M2, d: PAM5_P2};
    localparam quartet_t ESD2_EXT2   = '{a: PAM5_P2, b: PAM5_M2, c: PAM5_P2, d: PAM5_P2};
    localparam quartet_t ESD_EXT_ERR = '{a: PAM5_M2, b: PAM5_P2, c: PAM5_P2, d: PAM5_P2};

    // Data symbol table shared by encoder and decoder: 2 scrambled bits -> level.
    // Data uses only -2..+1, so no data quartet can ever look like a delimiter
    // (every delimiter contains at least three +2 symbols).
    localparam logic [3:0][2:0] PAM5_DATA_LUT = {3'b001, 3'b000, 3'b111, 3'b110};

    // Symbol value outside -2..+2 (3-bit encodings of +3, -4, -3).
    function automatic logic sym_out_of_range(input pam5_t s);
        return (s == 3'sb011) || (s == 3'sb100) || (s == 3'sb101);
    endfunction

    function automatic logic is_illegal(input quartet_t q);
        return sym_out_of_range(q.a) || sym_out_of_range(q.b) ||
               sym_out_of_range(q.c) || sym_out_of_range(q.d);
    endfunction

    // Level belongs to the data alphabet (-2..+1).
    function automatic logic is_data_sym(input pam5_t s);
        return (s == 3'sb110) || (s == 3'sb111) || (s == 3'sb000) || (s == 3'sb001);
    endfunction

    function automatic logic is_data_quartet(input quartet_t q);
        return is_data_sym(q.a) && is_data_sym(q.b) && is_data_sym(q.c) && is_data_sym(q.d);
    endfunction

    // Sd[8] reverses the symbol order on the wire.
    function automatic quartet_t swap_order(input quartet_t q);
        quartet_t r;
        r.a = q.d;
        r.b = q.c;
        r.c = q.b;
        r.d = q.a;
        return r;
    endfunction

    // Inverse of the data table: level + 2 gives the table index.
    function automatic logic [1:0] sym_to_bits(input pam5_t s);
        logic [2:0] t;
        t = s + 3'd2;
        return t[1:0];
    endfunction

    // Encoder data mapping: scramble with Sd[7:0], 2 bits per symbol, A carries the MSBs.
    function automatic quartet_t byte_to_pam5(input logic [7:0] data, input logic [8:0] sd);
        logic [7:0] s;
        quartet_t   q;
        s   = data ^ sd[7:0];
        q.a = PAM5_DATA_LUT[s[7:6]];
        q.b = PAM5_DATA_LUT[s[5:4]];
        q.c = PAM5_DATA_LUT[s[3:2]];
        q.d = PAM5_DATA_LUT[s[1:0]];
        return sd[8] ? swap_order(q) : q;
    endfunction

    // Exact inverse of byte_to_pam5 for the same Sd; meaningful only for data quartets.
    function automatic logic [7:0] pam5_to_byte(input quartet_t q, input logic [8:0] sd);
        quartet_t u;
        u = sd[8] ? swap_order(q) : q;
        return {sym_to_bits(u.a), sym_to_bits(u.b), sym_to_bits(u.c), sym_to_bits(u.d)} ^ sd[7:0];
    endfunction

endpackage

// File: rtl/pcs_rx_symbol_lut.sv
// Purpose: inverse data LUT, (quartet, Sd) -> (byte, illegal).
// Latency: combinational.
// Backpressure: none.
// Ports: quartet/sd in; byte_dat (0 when illegal) and illegal out.
module pcs_rx_symbol_lut
    import pcs_pkg::*;
(
    input  quartet_t    quartet,
    input  logic [8:0]  sd,
    output logic [7:0]  byte_dat,
    output logic        illegal
);

    // Out-of-range symbols and in-range quartets without a data preimage are both illegal;
    // illegal quartets decode to 0 so rxd is deterministic on error bytes.
    always_comb begin
        illegal  = is_illegal(quartet) || !is_data_quartet(quartet);
        byte_dat = illegal ? 8'h00 : pam5_to_byte(quartet, sd);
    end

endmodule

// File: rtl/pcs_rx_decoder.sv
// Purpose: 1000BASE-T PCS receive decoder, PAM5 quartets -> GMII rxd/rx_dv/rx_er.
// Latency: 1 cycle from strobe to io_rx_valid; data bytes appear one strobe later (lookahead).
// Backpressure: none; io_valid strobes are consumed unconditionally.
// Ports: clock/reset; io_valid, io_A..io_D, io_Sd, io_loc_rcvr_status in;
//        io_rx_valid, io_rxd, io_rx_dv, io_rx_er out (registered, held between strobes).
module pcs_rx_decoder
    import pcs_pkg::*;
#(
    parameter logic [7:0] FALSE_CARRIER_CODE = 8'h0E
)(
    input  logic        clock,
    input  logic        reset,
    input  logic        io_valid,
    input  logic [2:0]  io_A,
    input  logic [2:0]  io_B,
    input  logic [2:0]  io_C,
    input  logic [2:0]  io_D,
    input  logic [8:0]  io_Sd,
    input  logic        io_loc_rcvr_status,
    output logic        io_rx_valid,
    output logic [7:0]  io_rxd,
    output logic        io_rx_dv,
    output logic        io_rx_er
);

    quartet_t   rx_q;
    logic [7:0] lut_dat;
    logic       lut_illegal;

    rx_state_t  state_q, state_d;
    logic       hold_vld_q, hold_vld_d;
    logic [7:0] hold_dat_q, hold_dat_d;
    logic       hold_err_q, hold_err_d;

    logic [7:0] rxd_d;
    logic       dv_d, er_d;

    assign rx_q = {io_A, io_B, io_C, io_D};

    pcs_rx_symbol_lut u_lut (
        .quartet  (rx_q),
        .sd       (io_Sd),
        .byte_dat (lut_dat),
        .illegal  (lut_illegal)
    );

    always_comb begin
        state_d    = state_q;
        hold_vld_d = hold_vld_q;
        hold_dat_d = hold_dat_q;
        hold_err_d = hold_err_q;
        rxd_d      = 8'h00;
        dv_d       = 1'b0;
        er_d       = 1'b0;

        if (io_valid) begin
            if (!io_loc_rcvr_status && state_q != RX_IDLE) begin
                // Link lost: flag an open frame as errored, then drop everything.
                if (state_q == RX_DATA || state_q == RX_ESD_WAIT) begin
                    dv_d = 1'b1;
                    er_d = 1'b1;
                end
                state_d    = RX_IDLE;
                hold_vld_d = 1'b0;
            end else begin
                case (state_q)
                    RX_IDLE: begin
                        // Status low in IDLE lands here too: no delimiter detection then.
                        if (io_loc_rcvr_status && rx_q == SSD1) begin
                            state_d = RX_SSD_WAIT;
                        end
                    end
                    RX_SSD_WAIT: begin
                        if (rx_q == SSD2) begin
                            state_d    = RX_DATA;
                            hold_vld_d = 1'b0;
                        end else begin
                            state_d = RX_IDLE;
                            er_d    = 1'b1;
                            rxd_d   = FALSE_CARRIER_CODE;
                        end
                    end
                    RX_DATA: begin
                        // The previous quartet's byte leaves the hold register now.
                        if (hold_vld_q) begin
                            dv_d  = 1'b1;
                            er_d  = hold_err_q;
                            rxd_d = hold_dat_q;
                        end
                        if (rx_q == ESD1) begin
                            state_d    = RX_ESD_WAIT;
                            hold_vld_d = 1'b0;
                        end else begin
                            hold_vld_d = 1'b1;
                            hold_dat_d = lut_dat;
                            hold_err_d = lut_illegal;
                        end
                    end
                    RX_ESD_WAIT: begin
                        state_d = RX_IDLE;
                        if (rx_q == ESD2_EXT0 || rx_q == ESD2_EXT1 || rx_q == ESD2_EXT2) begin
                            er_d = 1'b0;
                        end else if (rx_q == ESD_EXT_ERR) begin
                            er_d = 1'b1;
                        end else begin
                            dv_d = 1'b1;
                            er_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d = RX_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RX_IDLE;
            hold_vld_q  <= 1'b0;
            hold_dat_q  <= 8'h00;
            hold_err_q  <= 1'b0;
            io_rx_valid <= 1'b0;
            io_rxd      <= 8'h00;
            io_rx_dv    <= 1'b0;
            io_rx_er    <= 1'b0;
        end else begin
            io_rx_valid <= io_valid;
            if (io_valid) begin
                state_q    <= state_d;
                hold_vld_q <= hold_vld_d;
                hold_dat_q <= hold_dat_d;
                hold_err_q <= hold_err_d;
                io_rxd     <= rxd_d;
                io_rx_dv   <= dv_d;
                io_rx_er   <= er_d;
            end
        end
    end

endmodule

// File: tb/tb_pcs_rx_decoder.sv
// Purpose: randomized self-checking bench for pcs_rx_decoder against a frame-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pcs_rx_decoder;
    import pcs_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       io_valid;
    logic [2:0] io_A, io_B, io_C, io_D;
    logic [8:0] io_Sd;
    logic       io_loc_rcvr_status;
    logic       io_rx_valid;
    logic [7:0] io_rxd;
    logic       io_rx_dv;
    logic       io_rx_er;

    int         n_total = 0;
    int         n_pass  = 0;
    logic [9:0] last_exp = 10'd0;   // {dv, er, rxd} expected to persist between strobes
    logic [7:0] fb[$];              // payload bytes of the next frame

    always #5 clock = ~clock;

    pcs_rx_decoder dut (
        .clock              (clock),
        .reset              (reset),
        .io_valid           (io_valid),
        .io_A               (io_A),
        .io_B               (io_B),
        .io_C               (io_C),
        .io_D               (io_D),
        .io_Sd              (io_Sd),
        .io_loc_rcvr_status (io_loc_rcvr_status),
        .io_rx_valid        (io_rx_valid),
        .io_rxd             (io_rxd),
        .io_rx_dv           (io_rx_dv),
        .io_rx_er           (io_rx_er)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [9:0] ob(input logic dv, input logic er, input logic [7:0] d);
        return {dv, er, d};
    endfunction

    function automatic logic [8:0] rsd();
        return 9'($urandom);
    endfunction

    function automatic pam5_t rand_sym();
        int r;
        r = $urandom_range(0, 15);
        case (r)
            0:       return 3'sb011;
            1:       return 3'sb100;
            2, 3:    return 3'sb110;
            4, 5:    return 3'sb111;
            6, 7, 8: return 3'sb000;
            9, 10:   return 3'sb001;
            default: return 3'sb010;
        endcase
    endfunction

    function automatic quartet_t rand_q();
        quartet_t q;
        q.a = rand_sym();
        q.b = rand_sym();
        q.c = rand_sym();
        q.d = rand_sym();
        return q;
    endfunction

    // Random idle cycles between strobes: nothing may change, no rx_valid.
    task automatic idle_gap();
        int k;
        k = $urandom_range(0, 2);
        for (int i = 0; i < k; i++) begin
            @(negedge clock);
            check("gap_rx_valid", 16'(io_rx_valid), 16'd0);
            check("gap_hold", 16'({io_rx_dv, io_rx_er, io_rxd}), 16'(last_exp));
        end
    endtask

    // Called at a negedge: present one quartet, then check the registered result.
    task automatic strobe(input string tag, input quartet_t q, input logic st,
                          input logic [9:0] exp, input logic [8:0] sd);
        io_valid = 1'b1;
        io_A = q.a; io_B = q.b; io_C = q.c; io_D = q.d;
        io_Sd = sd;
        io_loc_rcvr_status = st;
        @(negedge clock);
        io_valid = 1'b0;
        io_loc_rcvr_status = 1'b1;
        check("rx_valid", 16'(io_rx_valid), 16'd1);
        check(tag, 16'({io_rx_dv, io_rx_er, io_rxd}), 16'(exp));
        last_exp = exp;
        idle_gap();
    endtask

    // Frame model: delimiters produce nothing, each byte emerges one strobe late,
    // the last byte rides on ESD1, then the ending decides the final output.
    // ending: 0..2 = ESD2_Ext0..2, 3 = ESD_Ext_Err, other = bad second delimiter.
    task automatic run_frame(input int ending, input int ill_idx, input int drop_idx);
        logic [9:0] pend;
        logic       pend_vld;
        quartet_t   q;
        logic [8:0] sd;
        pend     = 10'd0;
        pend_vld = 1'b0;
        strobe("ssd1", SSD1, 1'b1, 10'd0, rsd());
        strobe("ssd2", SSD2, 1'b1, 10'd0, rsd());
        for (int i = 0; i < fb.size(); i++) begin
            sd = rsd();
            q  = byte_to_pam5(fb[i], sd);
            if (i == drop_idx) begin
                strobe("status_drop", q, 1'b0, ob(1'b1, 1'b1, 8'h00), sd);
                return;
            end
            if (i == ill_idx) q.a = 3'sb011;
            strobe("data", q, 1'b1, pend_vld ? pend : 10'd0, sd);
            pend     = (i == ill_idx) ? ob(1'b1, 1'b1, 8'h00) : ob(1'b1, 1'b0, fb[i]);
            pend_vld = 1'b1;
        end
        strobe("esd1", ESD1, 1'b1, pend_vld ? pend : 10'd0, rsd());
        case (ending)
            0: strobe("ext0", ESD2_EXT0, 1'b1, 10'd0, rsd());
            1: strobe("ext1", ESD2_EXT1, 1'b1, 10'd0, rsd());
            2: strobe("ext2", ESD2_EXT2, 1'b1, 10'd0, rsd());
            3: strobe("ext_err", ESD_EXT_ERR, 1'b1, ob(1'b0, 1'b1, 8'h00), rsd());
            default: begin
                sd = rsd();
                strobe("esd_bad", byte_to_pam5(8'($urandom), sd), 1'b1, ob(1'b1, 1'b1, 8'h00), sd);
            end
        endcase
    endtask

    task automatic fill_bytes(input int n);
        fb.delete();
        for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
    endtask

    task automatic false_carrier();
        quartet_t q;
        q = rand_q();
        if (q == SSD2) q.a = 3'sb000;
        strobe("fc_ssd1", SSD1, 1'b1, 10'd0, rsd());
        strobe("false_carrier", q, 1'b1, ob(1'b0, 1'b1, 8'h0E), rsd());
    endtask

    task automatic idle_strobe();
        quartet_t q;
        logic     st;
        q  = rand_q();
        st = ($urandom_range(0, 3) != 0);
        if (st && q == SSD1) q.a = 3'sb000;
        strobe("idle", q, st, 10'd0, rsd());
    endtask

    task automatic mid_reset();
        logic [8:0] sd;
        fill_bytes(2);
        strobe("mr_ssd1", SSD1, 1'b1, 10'd0, rsd());
        strobe("mr_ssd2", SSD2, 1'b1, 10'd0, rsd());
        sd = rsd();
        strobe("mr_d0", byte_to_pam5(fb[0], sd), 1'b1, 10'd0, sd);
        sd = rsd();
        strobe("mr_d1", byte_to_pam5(fb[1], sd), 1'b1, ob(1'b1, 1'b0, fb[0]), sd);
        reset = 1'b1;
        io_valid = 1'b1;
        io_A = 3'b000; io_B = 3'b001; io_C = 3'b111; io_D = 3'b110;
        @(negedge clock);
        reset = 1'b0;
        io_valid = 1'b0;
        check("mr_rx_valid", 16'(io_rx_valid), 16'd0);
        check("mr_outputs", 16'({io_rx_dv, io_rx_er, io_rxd}), 16'd0);
        last_exp = 10'd0;
        @(negedge clock);
        check("mr_rx_valid_after", 16'(io_rx_valid), 16'd0);
        check("mr_outputs_after", 16'({io_rx_dv, io_rx_er, io_rxd}), 16'd0);
    endtask

    initial begin
        reset = 1'b1;
        io_valid = 1'b0;
        io_A = '0; io_B = '0; io_C = '0; io_D = '0;
        io_Sd = '0;
        io_loc_rcvr_status = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_rx_valid", 16'(io_rx_valid), 16'd0);
        check("reset_outputs", 16'({io_rx_dv, io_rx_er, io_rxd}), 16'd0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) strobe("t1_zero", '0, 1'b1, 10'd0, rsd());

        fb = '{8'hF0, 8'h55, 8'hAA};
        run_frame(0, -1, -1);

        false_carrier();
        fill_bytes(3);
        run_frame(1, -1, -1);

        fill_bytes(5);
        run_frame(2, 2, -1);

        fill_bytes(4);
        run_frame(3, -1, -1);

        fill_bytes(5);
        run_frame(0, -1, 3);
        strobe("after_drop", '0, 1'b1, 10'd0, rsd());

        mid_reset();
        fill_bytes(3);
        run_frame(0, -1, -1);

        for (int it = 0; it < 60; it++) begin
            int act;
            int n;
            act = $urandom_range(0, 9);
            n   = $urandom_range(0, 6);
            if (act < 3) begin
                idle_strobe();
            end else if (act == 3) begin
                false_carrier();
            end else if (act == 4) begin
                // Link drop before data: no frame open yet, so no error.
                strobe("ssd_wait_ssd1", SSD1, 1'b1, 10'd0, rsd());
                strobe("ssd_wait_drop", SSD2, 1'b0, 10'd0, rsd());
            end else begin
                fill_bytes(n);
                run_frame($urandom_range(0, 4),
                          (n > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1,
                          (n > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
